ball_game_ctrl: RTL and testbench

Game-flow controller that sequences the ball movers. It owns the serve / play / score / game-over state machine and generates the shared movement strobe with a speed that rises on paddle hits. It also issues the restart pulse that recentres the ball, and keeps both players' scores. It sits between the collision/boundary detectors and the per-axis ball position registers, replacing their free-running internal tick counters.

---
 rtl/ball_game_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_ball_game_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_game_ctrl.sv
// Purpose: game-flow controller for the ball game. Sequences serve / play /
//          score / game-over, generates the shared ball movement strobe whose
//          period shrinks with paddle hits, issues ball restart pulses and
//          keeps both players' scores.
// Ports:   pclk, reset (async, active high); serve (level, rising edge acts),
//          pause (freeze), paddle_hit / miss_left / miss_right (pulses from the
//          collision and boundary detectors); step and ball_restart (one-cycle
//          strobes to the ball movers); score_l, score_r, speed_level,
//          game_state, game_over (status, all registered).
module ball_game_ctrl #(
    parameter int TICK_INIT      = 800_000,
    parameter int TICK_STEP      = 50_000,
    parameter int TICK_MIN       = 200_000,
    parameter int HITS_PER_LEVEL = 4,
    parameter int SERVE_DELAY    = 40_000_000,
    parameter int WIN_SCORE      = 9
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic       serve,
    input  logic       pause,
    input  logic       paddle_hit,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic       step,
    output logic       ball_restart,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic [2:0] speed_level,
    output logic [1:0] game_state,
    output logic       game_over
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SERVE = 2'd1,
        S_PLAY  = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    localparam int HW = (HITS_PER_LEVEL > 1) ? $clog2(HITS_PER_LEVEL) : 1;

    localparam logic [31:0]   T_INIT = 32'(TICK_INIT);
    localparam logic [31:0]   T_STEP = 32'(TICK_STEP);
    localparam logic [31:0]   T_MIN  = 32'(TICK_MIN);
    localparam logic [31:0]   SD_M1  = 32'(SERVE_DELAY - 1);
    localparam logic [HW-1:0] HPL_M1 = HW'(HITS_PER_LEVEL - 1);
    localparam logic [3:0]    WIN    = 4'(WIN_SCORE);
    // How far the period may drop below TICK_INIT before it hits the floor.
    // Zero when the floor is at or above TICK_INIT, so the floor always wins.
    localparam logic [31:0]   HEADROOM = (TICK_INIT > TICK_MIN) ?
                                         32'(TICK_INIT - TICK_MIN) : 32'd0;

    state_t      state, state_n;
    logic        serve_q;
    logic [31:0] serve_cnt, serve_cnt_n;
    logic [31:0] tick_cnt, tick_cnt_n;
    logic [HW-1:0] hit_cnt, hit_cnt_n;
    logic [2:0]  level_n;
    logic [3:0]  score_l_n, score_r_n;
    logic        step_n, restart_n;
    logic        serve_rise;
    logic [31:0] dec;
    logic [31:0] period;

    // Period is clamped by comparing against the headroom first, so the
    // subtraction below can never wrap.
    assign dec    = 32'(speed_level) * T_STEP;
    assign period = (dec >= HEADROOM) ? T_MIN : (T_INIT - dec);

    assign serve_rise = serve & ~serve_q;
    assign game_state = state;

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            serve_q      <= 1'b0;
            serve_cnt    <= '0;
            tick_cnt     <= '0;
            hit_cnt      <= '0;
            speed_level  <= '0;
            score_l      <= '0;
            score_r      <= '0;
            step         <= 1'b0;
            ball_restart <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            state        <= state_n;
            serve_q      <= serve;
            serve_cnt    <= serve_cnt_n;
            tick_cnt     <= tick_cnt_n;
            hit_cnt      <= hit_cnt_n;
            speed_level  <= level_n;
            score_l      <= score_l_n;
            score_r      <= score_r_n;
            step         <= step_n;
            ball_restart <= restart_n;
            game_over    <= (state_n == S_OVER);
        end
    end

    always_comb begin
        state_n     = state;
        serve_cnt_n = serve_cnt;
        tick_cnt_n  = tick_cnt;
        hit_cnt_n   = hit_cnt;
        level_n     = speed_level;
        score_l_n   = score_l;
        score_r_n   = score_r;
        step_n      = 1'b0;
        restart_n   = 1'b0;

        case (state)
            S_IDLE: begin
                if (serve_rise) begin
                    state_n     = S_SERVE;
                    restart_n   = 1'b1;
                    serve_cnt_n = '0;
                end
            end

            S_SERVE: begin
                if (!pause) begin
                    if (serve_cnt == SD_M1) begin
                        state_n    = S_PLAY;
                        tick_cnt_n = period - 32'd1;
                    end else begin
                        serve_cnt_n = serve_cnt + 32'd1;
                    end
                end
            end

            S_PLAY: begin
                // A miss is honoured even while paused and swallows any
                // step or hit in the same cycle.
                if (miss_left || miss_right) begin
                    if (miss_left && !miss_right)
                        score_r_n = score_r + 4'd1;
                    if (miss_right && !miss_left)
                        score_l_n = score_l + 4'd1;
                    level_n     = '0;
                    hit_cnt_n   = '0;
                    restart_n   = 1'b1;
                    serve_cnt_n = '0;
                    state_n     = (score_l_n == WIN || score_r_n == WIN) ?
                                  S_OVER : S_SERVE;
                end else if (!pause) begin
                    // Reload uses the period of the level held this cycle;
                    // a level change from a coincident hit applies next time.
                    if (tick_cnt == '0) begin
                        tick_cnt_n = period - 32'd1;
                        step_n     = 1'b1;
                    end else begin
                        tick_cnt_n = tick_cnt - 32'd1;
                    end
                    if (paddle_hit) begin
                        if (hit_cnt == HPL_M1) begin
                            hit_cnt_n = '0;
                            if (speed_level != 3'd7)
                                level_n = speed_level + 3'd1;
                        end else begin
                            hit_cnt_n = hit_cnt + HW'(1);
                        end
                    end
                end
            end

            S_OVER: begin
                if (serve_rise) begin
                    score_l_n = '0;
                    score_r_n = '0;
                    restart_n = 1'b1;
                    state_n   = S_IDLE;
                end
            end

            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ball_game_ctrl.sv
// Bench for ball_game_ctrl: a reference model tracks the game as phases with
// elapsed-versus-target wait lengths and is compared against the DUT each
// cycle; directed scenarios add hand-computed spacing, score and level checks.
module tb_ball_game_ctrl;

    localparam int TICK_INIT      = 20;
    localparam int TICK_STEP      = 4;
    localparam int TICK_MIN       = 8;
    localparam int HITS_PER_LEVEL = 2;
    localparam int SERVE_DELAY    = 10;
    localparam int WIN_SCORE      = 3;

    logic       pclk = 1'b0;
    logic       reset = 1'b0;
    logic       serve = 1'b0;
    logic       pause = 1'b0;
    logic       paddle_hit = 1'b0;
    logic       miss_left = 1'b0;
    logic       miss_right = 1'b0;
    logic       step;
    logic       ball_restart;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic [2:0] speed_level;
    logic [1:0] game_state;
    logic       game_over;

    ball_game_ctrl #(
        .TICK_INIT      (TICK_INIT),
        .TICK_STEP      (TICK_STEP),
        .TICK_MIN       (TICK_MIN),
        .HITS_PER_LEVEL (HITS_PER_LEVEL),
        .SERVE_DELAY    (SERVE_DELAY),
        .WIN_SCORE      (WIN_SCORE)
    ) dut (
        .pclk         (pclk),
        .reset        (reset),
        .serve        (serve),
        .pause        (pause),
        .paddle_hit   (paddle_hit),
        .miss_left    (miss_left),
        .miss_right   (miss_right),
        .step         (step),
        .ball_restart (ball_restart),
        .score_l      (score_l),
        .score_r      (score_r),
        .speed_level  (speed_level),
        .game_state   (game_state),
        .game_over    (game_over)
    );

    always #5 pclk = ~pclk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_steps  = 0;
    int n_rst    = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // phase 0 idle, 1 serve, 2 play, 3 game over. In serve/play, 'elapsed'
    // counts unpaused cycles spent waiting and 'target' is the wait length.
    typedef struct {
        int phase;
        int elapsed;
        int target;
        int hits;
        int level;
        int sl;
        int sr;
        bit step;
        bit restart;
        bit serve_prev;
    } mstate_t;

    mstate_t m;

    function automatic int period_of(input int lvl);
        int p;
        p = TICK_INIT - lvl * TICK_STEP;
        return (p < TICK_MIN) ? TICK_MIN : p;
    endfunction

    function automatic mstate_t model_next(input mstate_t s, input logic sv,
                                           input logic ps, input logic hit,
                                           input logic ml, input logic mr);
        mstate_t n;
        bit rise;
        n = s;
        rise = sv && !s.serve_prev;
        n.serve_prev = sv;
        n.step = 0;
        n.restart = 0;
        case (s.phase)
            0: if (rise) begin
                n.phase = 1; n.elapsed = 0; n.restart = 1;
            end
            1: if (!ps) begin
                n.elapsed = s.elapsed + 1;
                if (n.elapsed == SERVE_DELAY) begin
                    n.phase = 2; n.elapsed = 0; n.target = period_of(s.level);
                end
            end
            2: if (ml || mr) begin
                if (ml && !mr) n.sr = s.sr + 1;
                if (mr && !ml) n.sl = s.sl + 1;
                n.level = 0; n.hits = 0; n.restart = 1; n.elapsed = 0;
                n.phase = (n.sl == WIN_SCORE || n.sr == WIN_SCORE) ? 3 : 1;
            end else if (!ps) begin
                n.elapsed = s.elapsed + 1;
                if (n.elapsed == s.target) begin
                    n.step = 1; n.elapsed = 0; n.target = period_of(s.level);
                end
                if (hit) begin
                    n.hits = s.hits + 1;
                    if (n.hits == HITS_PER_LEVEL) begin
                        n.hits = 0;
                        if (s.level < 7) n.level = s.level + 1;
                    end
                end
            end
            default: if (rise) begin
                n.sl = 0; n.sr = 0; n.restart = 1; n.phase = 0;
            end
        endcase
        return n;
    endfunction

    always begin
        @(posedge pclk or posedge reset);
        if (reset) m = '{default: 0};
        else m = model_next(m, serve, pause, paddle_hit, miss_left, miss_right);
    end

    always begin
        @(posedge pclk);
        cyc = cyc + 1;
    end

    // Per-cycle comparison against the model, away from the active edge.
    always begin
        @(negedge pclk);
        check("step",         int'(step),         int'(m.step));
        check("ball_restart", int'(ball_restart), int'(m.restart));
        check("score_l",      int'(score_l),      m.sl);
        check("score_r",      int'(score_r),      m.sr);
        check("speed_level",  int'(speed_level),  m.level);
        check("game_state",   int'(game_state),   m.phase);
        check("game_over",    int'(game_over),    int'(m.phase == 3));
        if (step) n_steps = n_steps + 1;
        if (ball_restart) n_rst = n_rst + 1;
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic wait_step(output int t);
        bit found;
        found = 0;
        t = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(posedge pclk);
            #1;
            if (step) begin
                found = 1;
                t = cyc;
            end
        end
        check("step_arrives", int'(found), 1);
    endtask

    task automatic miss(input logic l, input logic r);
        miss_left = l;
        miss_right = r;
        tick(1);
        miss_left = 1'b0;
        miss_right = 1'b0;
    endtask

    initial begin
        int t0, t1, t2, t3, t4, t5, t6, s0, r0;

        // Reset state
        reset = 1'b1;
        tick(2);
        check("rst_state", int'(game_state), 0);
        check("rst_step", int'(step), 0);
        check("rst_scores", int'({score_l, score_r}), 0);
        reset = 1'b0;
        tick(2);

        // Serve: restart next cycle, first step 30 later, then every 20
        serve = 1'b1;
        tick(1);
        check("serve_restart", int'(ball_restart), 1);
        check("serve_state", int'(game_state), 1);
        t0 = cyc;
        serve = 1'b0;
        wait_step(t1);
        check("first_step_delay", t1 - t0, 30);
        wait_step(t2);
        check("step_spacing_l0", t2 - t1, 20);

        // Two hits -> level 1; in-flight interval keeps 20, then 16
        paddle_hit = 1'b1;
        tick(2);
        paddle_hit = 1'b0;
        check("level_after_2_hits", int'(speed_level), 1);
        wait_step(t3);
        check("inflight_not_shortened", t3 - t2, 20);
        wait_step(t4);
        check("step_spacing_l1", t4 - t3, 16);

        // Eight more -> level 5, period clamps at 8
        paddle_hit = 1'b1;
        tick(8);
        paddle_hit = 1'b0;
        check("level_after_10_hits", int'(speed_level), 5);
        wait_step(t5);
        check("inflight_l1_period", t5 - t4, 16);
        wait_step(t6);
        check("step_spacing_clamped", t6 - t5, 8);

        // Saturation at level 7
        paddle_hit = 1'b1;
        tick(6);
        paddle_hit = 1'b0;
        check("level_saturates", int'(speed_level), 7);

        // miss_right -> left scores, level cleared, back to serve
        miss(1'b0, 1'b1);
        check("miss_r_score_l", int'(score_l), 1);
        check("miss_r_level", int'(speed_level), 0);
        check("miss_r_restart", int'(ball_restart), 1);
        check("miss_r_state", int'(game_state), 1);
        t0 = cyc;

        // Pause 5 cycles during serve delays first step by 5
        tick(2);
        pause = 1'b1;
        tick(5);
        pause = 1'b0;
        wait_step(t1);
        check("serve_pause_delay", t1 - t0, 35);

        // Pause 5 cycles mid-interval in play, hits during pause ignored
        tick(3);
        pause = 1'b1;
        paddle_hit = 1'b1;
        tick(5);
        pause = 1'b0;
        paddle_hit = 1'b0;
        wait_step(t2);
        check("play_pause_interval", t2 - t1, 25);
        check("paused_hits_ignored", int'(speed_level), 0);

        // Simultaneous misses: no score change, back to serve
        miss(1'b1, 1'b1);
        check("both_miss_score_l", int'(score_l), 1);
        check("both_miss_score_r", int'(score_r), 0);
        check("both_miss_state", int'(game_state), 1);

        // Three miss_left -> right wins
        for (int i = 1; i <= 3; i++) begin
            wait_step(t3);
            miss(1'b1, 1'b0);
            check("miss_l_score_r", int'(score_r), i);
        end
        check("over_state", int'(game_state), 3);
        check("over_flag", int'(game_over), 1);
        s0 = n_steps;
        tick(60);
        check("over_no_steps", n_steps - s0, 0);
        check("over_scores_hold", int'(score_r), 3);

        // Serve edge -> idle with cleared scores; held serve does nothing more
        serve = 1'b1;
        tick(1);
        check("restart_state", int'(game_state), 0);
        check("restart_scores", int'({score_l, score_r}), 0);
        check("restart_pulse", int'(ball_restart), 1);
        tick(10);
        check("held_serve_idle", int'(game_state), 0);
        serve = 1'b0;
        tick(1);

        // Reach play with score_l = 2, then async reset mid-cycle
        serve = 1'b1;
        tick(1);
        serve = 1'b0;
        wait_step(t4);
        miss(1'b0, 1'b1);
        wait_step(t4);
        miss(1'b0, 1'b1);
        wait_step(t4);
        check("pre_reset_score_l", int'(score_l), 2);
        tick(3);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_state", int'(game_state), 0);
        check("async_rst_score_l", int'(score_l), 0);
        check("async_rst_level", int'(speed_level), 0);
        tick(2);
        reset = 1'b0;
        s0 = n_steps;
        r0 = n_rst;
        tick(50);
        check("post_reset_no_step", n_steps - s0, 0);
        check("post_reset_no_restart", n_rst - r0, 0);
        check("post_reset_idle", int'(game_state), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
